// File: rtl/shift_loader.sv
// Parallel-to-serial loader: feeds one WIDTH-bit word, one bit per cycle, into a
// downstream shift register. Optional abort port enabled by SHIFT_LOADER_ABORT_EN.
module shift_loader #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dir_in,
    input  logic             load_valid,
`ifdef SHIFT_LOADER_ABORT_EN
    input  logic             abort,
`endif
    output logic             load_ready,
    output logic             y,
    output logic             sh,
    output logic             rt,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             y_q, y_d;
    logic             sh_q, sh_d;
    logic             rt_q, rt_d;
    logic             done_q, done_d;
    logic             abort_w;

`ifdef SHIFT_LOADER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // sreg holds the bits not yet presented; the outgoing bit always sits at the
    // end selected by rt, so the register shifts toward that end each cycle.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        y_d     = y_q;
        sh_d    = sh_q;
        rt_d    = rt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                sh_d    = 1'b0;
                y_d     = 1'b0;
                if (load_valid) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    rt_d    = dir_in;
                    sh_d    = 1'b1;
                    ready_d = 1'b0;
                    y_d     = dir_in ? data_in[0] : data_in[WIDTH-1];
                    sreg_d  = dir_in ? (data_in >> 1) : (data_in << 1);
                end
            end
            SHIFT: begin
                if (abort_w) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sh_d    = 1'b0;
                    y_d     = 1'b0;
                    ready_d = 1'b1;
                end else if (cnt_q == LAST) begin
                    state_d = DONE;
                    sh_d    = 1'b0;
                    y_d     = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    y_d    = rt_q ? sreg_q[0] : sreg_q[WIDTH-1];
                    sreg_d = rt_q ? (sreg_q >> 1) : (sreg_q << 1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                ready_d = 1'b1;
                sh_d    = 1'b0;
                y_d     = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                ready_d = 1'b1;
                sh_d    = 1'b0;
                y_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            y_q     <= 1'b0;
            sh_q    <= 1'b0;
            rt_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            y_q     <= y_d;
            sh_q    <= sh_d;
            rt_q    <= rt_d;
            done_q  <= done_d;
        end
    end

    assign load_ready = ready_q;
    assign y          = y_q;
    assign sh         = sh_q;
    assign rt         = rt_q;
    assign done       = done_q;

endmodule

// File: tb/tb_shift_loader.sv
// Scoreboard bench for shift_loader: accepted words queue their expected serial
// bits; a downstream shift register model rebuilds each word and is checked on done.
module tb_shift_loader;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_in;
    logic         dir_in;
    logic         load_valid;
    logic         abort;
    logic         load_ready, y, sh, rt, done;

    always #5 clk = ~clk;

    shift_loader #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .dir_in     (dir_in),
        .load_valid (load_valid),
`ifdef SHIFT_LOADER_ABORT_EN
        .abort      (abort),
`endif
        .load_ready (load_ready),
        .y          (y),
        .sh         (sh),
        .rt         (rt),
        .done       (done)
    );

    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           n_acc = 0;
    int           n_done = 0;
    bit           mon_en = 1'b0;
    logic [W-1:0] ds = '0;
    logic [1:0]   exp_bits[$];
    logic [W-1:0] exp_word[$];
    int           exp_t[$];
    int           acc_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push_word(input logic [W-1:0] d, input logic dr, input int c);
        logic [W-1:0] t;
        t = d;
        for (int k = 0; k < W; k++) begin
            if (dr) begin
                exp_bits.push_back({dr, t[0]});
                t = t >> 1;
            end else begin
                exp_bits.push_back({dr, t[W-1]});
                t = t << 1;
            end
        end
        exp_word.push_back(d);
        exp_t.push_back(c);
        acc_cyc.push_back(c);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && load_valid && load_ready) begin
            push_word(data_in, dir_in, cyc);
            n_acc <= n_acc + 1;
        end
    end

    // Monitor and downstream register model, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sh) begin
                chk("rdy_in_shift", {31'b0, load_ready}, 32'd0);
                if (exp_bits.size() == 0) chk("sh_extra", 32'd1, 32'd0);
                else chk("y_rt", {30'b0, rt, y}, {30'b0, exp_bits.pop_front()});
                ds <= rt ? {y, ds[W-1:1]} : {ds[W-2:0], y};
            end else begin
                chk("y_idle", {31'b0, y}, 32'd0);
            end
            if (done) begin
                n_done <= n_done + 1;
                if (exp_word.size() == 0) chk("done_unexp", 32'd1, 32'd0);
                else begin
                    chk("q_ds", {27'b0, ds}, {27'b0, exp_word.pop_front()});
                    chk("bits_left", exp_bits.size(), 32'd0);
                    chk("latency", cyc - exp_t.pop_front(), W + 1);
                end
            end
        end
    end

    // Call at a negedge; returns at the negedge of SHIFT cycle 0.
    task automatic send(input logic [W-1:0] d, input logic dr);
        int n = 0;
        data_in = d; dir_in = dr; load_valid = 1'b1;
        while (!load_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!load_ready) chk("send_timeout", {31'b0, load_ready}, 32'd1);
        else @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        data_in = W'($urandom);
        dir_in = 1'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((exp_bits.size() != 0 || exp_word.size() != 0 || !load_ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, (n < 60) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic flush();
        exp_bits.delete();
        exp_word.delete();
        exp_t.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n, d0;
        rst = 1'b1; load_valid = 1'b0; data_in = '0; dir_in = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {31'b0, load_ready}, 32'd1);
        chk("rst_sh",    {31'b0, sh},   32'd0);
        chk("rst_y",     {31'b0, y},    32'd0);
        chk("rst_rt",    {31'b0, rt},   32'd0);
        chk("rst_done",  {31'b0, done}, 32'd0);
        mon_en = 1'b1;

        send(5'b10110, 1'b1);
        wait_idle("idle_right");
        send(5'b10110, 1'b0);
        wait_idle("idle_left");

        // load_valid held high across two words; data changes mid-SHIFT
        base = n_acc; n = 0;
        data_in = 5'b11111; dir_in = 1'b1; load_valid = 1'b1;
        while (n_acc < base + 1 && n < 20) begin @(negedge clk); n++; end
        data_in = 5'b00001; dir_in = 1'b0;
        while (n_acc < base + 2 && n < 40) begin @(negedge clk); n++; end
        load_valid = 1'b0;
        data_in = 5'b10101; dir_in = 1'b1;
        chk("b2b_count", n_acc - base, 32'd2);
        if (acc_cyc.size() >= 2)
            chk("b2b_gap", acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2], W + 2);
        wait_idle("idle_b2b");

        for (int i = 0; i < 8; i++) send(W'($urandom), 1'($urandom));
        wait_idle("idle_rand");
        send(5'b00000, 1'b1);
        send(5'b11111, 1'b0);
        wait_idle("idle_edge");

        // reset wins over a simultaneous transfer
        data_in = 5'b01011; dir_in = 1'b1; load_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; load_valid = 1'b0;
        chk("rstpri_sh",  {31'b0, sh}, 32'd0);
        chk("rstpri_rdy", {31'b0, load_ready}, 32'd1);

        // reset in SHIFT cycle 2 truncates the word without a done pulse
        d0 = n_done;
        send(5'b11010, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_sh",   {31'b0, sh}, 32'd0);
        chk("rstmid_rdy",  {31'b0, load_ready}, 32'd1);
        chk("rstmid_done", {31'b0, done}, 32'd0);
        chk("rstmid_rt",   {31'b0, rt}, 32'd0);
        flush();
        repeat (W + 3) @(negedge clk);
        chk("rstmid_nodone", n_done - d0, 32'd0);

`ifdef SHIFT_LOADER_ABORT_EN
        // abort in SHIFT cycle 3, then a fresh load the very next cycle
        d0 = n_done;
        send(5'b01101, 1'b0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_sh",   {31'b0, sh}, 32'd0);
        chk("abort_rdy",  {31'b0, load_ready}, 32'd1);
        chk("abort_done", {31'b0, done}, 32'd0);
        flush();
        base = n_acc;
        send(5'b10011, 1'b1);
        chk("abort_reload", n_acc - base, 32'd1);
        wait_idle("idle_abort");
        chk("abort_one_done", n_done - d0, 32'd1);
        // abort in IDLE is ignored
        abort = 1'b1;
        @(negedge clk);
        chk("abort_idle_rdy", {31'b0, load_ready}, 32'd1);
        send(5'b01110, 1'b1);
        abort = 1'b0;
        wait_idle("idle_abort2");
`endif

        repeat (3) @(negedge clk);
        chk("final_q_empty", exp_word.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
